// File: rtl/reg_wb_pkg.sv
// rtl/reg_wb_pkg.sv - shared constants and entry type for the register writeback block
package reg_wb_pkg;

    localparam int NUM_REGS  = 8;
    localparam int REG_WIDTH = 16;
    localparam int RW        = $clog2(NUM_REGS);
    localparam int DEPTH     = 4;
    // Counter must hold every reservation that can be outstanding beyond the queue
    localparam int SB_W      = $clog2(DEPTH + 3);

    typedef struct packed {
        logic [RW-1:0]        rd;
        logic [REG_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - in-order circular buffer with two push ports and one pop port
module wb_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             push_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    slot_b;
    logic [1:0]       n_push;

    // Port b lands behind port a when both push, so a is always older
    always_comb begin
        slot_b = push_a ? wr_ptr + AW'(1) : wr_ptr;
        n_push = {1'b0, push_a} + {1'b0, push_b};
    end

    always_ff @(posedge clk) begin
        if (push_a)
            mem[wr_ptr] <= data_a;
        if (push_b)
            mem[slot_b] <= data_b;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_push);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(n_push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - ALU/load result collector, writeback queue and RAW scoreboard (option: REG_WRITEBACK_BYPASS_EN)
module reg_writeback #(
    parameter int NUM_REGS  = reg_wb_pkg::NUM_REGS,
    parameter int REG_WIDTH = reg_wb_pkg::REG_WIDTH,
    parameter int DEPTH     = reg_wb_pkg::DEPTH,
    localparam int RW       = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [RW-1:0]        alu_rd,
    input  logic [REG_WIDTH-1:0] alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [RW-1:0]        mem_rd,
    input  logic [REG_WIDTH-1:0] mem_data,
    input  logic                 issue_valid,
    input  logic [RW-1:0]        issue_rd,
    output logic                 issue_ready,
    input  logic [RW-1:0]        rs_q,
    input  logic [RW-1:0]        rt_q,
    output logic                 rs_busy,
    output logic                 rt_busy,
    output logic                 wb_write_en,
    output logic [RW-1:0]        wb_rd,
    output logic [REG_WIDTH-1:0] wb_data
);

    localparam int CW   = $clog2(DEPTH + 1);
    localparam int EW   = RW + REG_WIDTH;
    localparam int SB_W = $clog2(DEPTH + 3);
    localparam logic [SB_W-1:0] SB_MAX = '1;

    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic [EW-1:0] head;
    logic          fifo_empty;
    logic          alu_en;
    logic          mem_en;
    logic          byp_alu;
    logic          byp_mem;
    logic          push_a;
    logic          push_b;
    logic          pop;
    logic          sb_inc;

    logic [SB_W-1:0] sb [NUM_REGS];

    always_comb begin
        free       = CW'(DEPTH) - count;
        fifo_empty = (count == '0);
        alu_ready  = (free != '0);
        mem_ready  = (free >= CW'(2)) || ((free == CW'(1)) && !alu_valid);
        // r0 results complete the handshake but never occupy a slot
        alu_en     = alu_valid && alu_ready && (alu_rd != '0);
        mem_en     = mem_valid && mem_ready && (mem_rd != '0);
        pop        = !fifo_empty;
    end

`ifdef REG_WRITEBACK_BYPASS_EN
    // Only an empty queue may be skipped, otherwise older writes would be overtaken
    assign byp_alu = fifo_empty && alu_en;
    assign byp_mem = fifo_empty && !alu_en && mem_en;
`else
    assign byp_alu = 1'b0;
    assign byp_mem = 1'b0;
`endif

    assign push_a = alu_en && !byp_alu;
    assign push_b = mem_en && !byp_mem;

    wb_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_a (push_a),
        .data_a ({alu_rd, alu_data}),
        .push_b (push_b),
        .data_b ({mem_rd, mem_data}),
        .pop    (pop),
        .head   (head),
        .count  (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_write_en <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
        end else if (pop) begin
            wb_write_en <= 1'b1;
            {wb_rd, wb_data} <= head;
        end else if (byp_alu) begin
            wb_write_en <= 1'b1;
            wb_rd       <= alu_rd;
            wb_data     <= alu_data;
        end else if (byp_mem) begin
            wb_write_en <= 1'b1;
            wb_rd       <= mem_rd;
            wb_data     <= mem_data;
        end else begin
            wb_write_en <= 1'b0;
        end
    end

    assign issue_ready = (sb[issue_rd] != SB_MAX);
    assign sb_inc      = issue_valid && issue_ready && (issue_rd != '0);

    // Retirement is the edge at which the register file captures wb_*
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                sb[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (sb_inc && (issue_rd == RW'(i)) &&
                    !(wb_write_en && (wb_rd == RW'(i)) && (sb[i] != '0)))
                    sb[i] <= sb[i] + SB_W'(1);
                else if (!(sb_inc && (issue_rd == RW'(i))) &&
                         wb_write_en && (wb_rd == RW'(i)) && (sb[i] != '0))
                    sb[i] <= sb[i] - SB_W'(1);
            end
        end
    end

    assign rs_busy = (rs_q != '0) && (sb[rs_q] != '0);
    assign rt_busy = (rt_q != '0) && (sb[rt_q] != '0);

endmodule
